// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
//
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Serves a single outstanding fetch request from IF.
// - A hit answers one cycle after the request is sampled.
// - A miss issues a word read to the memory controller, refills the line and
//   then answers.
// - A ROB flush (jump_wrong) cancels the response. It never cancels the
//   memory transfer, so refilled lines always hold correct data.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-low reset
//   rdy            in   global ready, 0 freezes all state
//   icache_enable  in   fetch request (level, held until success)
//   pc_to_fetch    in   fetch address, bits [1:0] ignored
//   instr_fetched  out  instruction word, valid with icache_success
//   icache_success out  one-cycle response strobe
//   jump_wrong     in   ROB flush, cancels the current request
//   mem_enable     out  word read request to the memory controller (level)
//   mem_addr       out  word-aligned read address
//   mem_data       in   read data, valid with mem_success
//   mem_success    in   one-cycle completion strobe from memory
// -----------------------------------------------------------------------------
module icache #(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  icache_enable,
    input  logic [ADDR_WIDTH-1:0] pc_to_fetch,
    output logic [31:0]           instr_fetched,
    output logic                  icache_success,
    input  logic                  jump_wrong,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data,
    input  logic                  mem_success
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MISS  = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // Line storage
    logic [LINES-1:0]        r_valid;
    logic [TAG_BITS-1:0]     r_tag  [LINES];
    logic [31:0]             r_data [LINES];

    // Line being refilled by the outstanding memory read
    logic [INDEX_BITS-1:0]   r_miss_index;
    logic [TAG_BITS-1:0]     r_miss_tag;

    // Output registers
    logic                    r_success;
    logic [31:0]             r_instr;
    logic                    r_mem_en;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;

    // Request decode
    logic [INDEX_BITS-1:0]   w_index;
    logic [TAG_BITS-1:0]     w_tag;
    logic [ADDR_WIDTH-1:0]   w_word_addr;
    logic                    w_hit;

    // Next-state values from the FSM
    logic                    w_success_nxt;
    logic [31:0]             w_instr_nxt;
    logic                    w_mem_en_nxt;
    logic [ADDR_WIDTH-1:0]   w_mem_addr_nxt;
    logic                    w_latch_miss;
    logic                    w_refill;

    assign w_index     = pc_to_fetch[INDEX_BITS+1:2];
    assign w_tag       = pc_to_fetch[ADDR_WIDTH-1:INDEX_BITS+2];
    // Masking, rather than slicing, keeps the whole address word in use.
    assign w_word_addr = pc_to_fetch & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);

    assign instr_fetched = r_instr;
    assign mem_enable    = r_mem_en;
    assign mem_addr      = r_mem_addr;
    // A flush in the RESP cycle must suppress that very cycle's strobe.
    // The flush therefore gates the registered strobe combinationally.
    assign icache_success = r_success & ~jump_wrong;

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_success_nxt  = 1'b0;
        w_instr_nxt    = r_instr;
        w_mem_en_nxt   = r_mem_en;
        w_mem_addr_nxt = r_mem_addr;
        w_latch_miss   = 1'b0;
        w_refill       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (jump_wrong) begin
                    w_state_nxt = S_IDLE;
                end else if (icache_enable) begin
                    if (w_hit) begin
                        w_instr_nxt   = r_data[w_index];
                        w_success_nxt = 1'b1;
                        w_state_nxt   = S_RESP;
                    end else begin
                        w_mem_addr_nxt = w_word_addr;
                        w_mem_en_nxt   = 1'b1;
                        w_latch_miss   = 1'b1;
                        w_state_nxt    = S_MISS;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_MISS: begin
                if (mem_success) begin
                    // The line is refilled even when the response is flushed.
                    w_refill     = 1'b1;
                    w_mem_en_nxt = 1'b0;
                    if (jump_wrong) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_instr_nxt   = mem_data;
                        w_success_nxt = 1'b1;
                        w_state_nxt   = S_RESP;
                    end
                end else if (jump_wrong) begin
                    // The memory read cannot be aborted, so wait it out silently.
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_MISS;
                end
            end

            S_RESP: begin
                // icache_enable is ignored here. RESP always returns to IDLE.
                w_state_nxt = S_IDLE;
            end

            S_DRAIN: begin
                if (mem_success) begin
                    w_refill     = 1'b1;
                    w_mem_en_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end

            default: begin
                w_mem_en_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Output, miss-context and valid-bit registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_success    <= 1'b0;
            r_instr      <= 32'd0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_miss_index <= '0;
            r_miss_tag   <= '0;
            r_valid      <= '0;
        end else if (rdy) begin
            r_success  <= w_success_nxt;
            r_instr    <= w_instr_nxt;
            r_mem_en   <= w_mem_en_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            if (w_latch_miss) begin
                r_miss_index <= w_index;
                r_miss_tag   <= w_tag;
            end
            if (w_refill) begin
                r_valid[r_miss_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays. Valid bits alone qualify their contents, so they need no reset.
    always_ff @(posedge clk) begin
        if (rst && rdy && w_refill) begin
            r_tag[r_miss_index]  <= r_miss_tag;
            r_data[r_miss_index] <= mem_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
//
// Directed bench for icache (INDEX_BITS=8, ADDR_WIDTH=32).
// Each vector record is one clock cycle.
// - Inputs are driven at the falling edge.
// - Outputs are compared 1 time unit later, so the expected values describe
//   the outputs seen during that cycle, before the next rising edge.
// - chk bit mask: [0] icache_success, [1] mem_enable, [2] mem_addr,
//   [3] instr_fetched.
// -----------------------------------------------------------------------------
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        icache_enable;
    logic [31:0] pc_to_fetch;
    logic [31:0] instr_fetched;
    logic        icache_success;
    logic        jump_wrong;
    logic        mem_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_success;

    int n_vec = 0;
    int n_bad = 0;
    int step_id = 0;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        en;
        logic [31:0] pc;
        logic        jw;
        logic [31:0] md;
        logic        ms;
        logic [3:0]  chk;
        logic        exp_succ;
        logic        exp_men;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
    } vec_t;

    localparam logic [3:0] C_ALL = 4'hF;
    localparam logic [3:0] C_SM  = 4'h3;
    localparam logic [3:0] C_SMA = 4'h7;
    localparam logic [3:0] C_SMI = 4'hB;

    icache #(
        .INDEX_BITS(8),
        .ADDR_WIDTH(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .icache_enable  (icache_enable),
        .pc_to_fetch    (pc_to_fetch),
        .instr_fetched  (instr_fetched),
        .icache_success (icache_success),
        .jump_wrong     (jump_wrong),
        .mem_enable     (mem_enable),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_success    (mem_success)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r_n, input logic rd, input logic en,
                                input logic [31:0] pc, input logic jw,
                                input logic [31:0] md, input logic ms,
                                input logic [3:0] chk, input logic es,
                                input logic eme, input logic [31:0] ema,
                                input logic [31:0] ei);
        vec_t v;
        v.rst_n = r_n; v.rdy = rd; v.en = en; v.pc = pc; v.jw = jw;
        v.md = md; v.ms = ms; v.chk = chk; v.exp_succ = es;
        v.exp_men = eme; v.exp_addr = ema; v.exp_instr = ei;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL step %0d %s: got %h, want %h", step_id, name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst           = v.rst_n;
        rdy           = v.rdy;
        icache_enable = v.en;
        pc_to_fetch   = v.pc;
        jump_wrong    = v.jw;
        mem_data      = v.md;
        mem_success   = v.ms;
        #1;
        if (v.chk[0]) cmp("icache_success", {31'd0, icache_success}, {31'd0, v.exp_succ});
        if (v.chk[1]) cmp("mem_enable", {31'd0, mem_enable}, {31'd0, v.exp_men});
        if (v.chk[2]) cmp("mem_addr", mem_addr, v.exp_addr);
        if (v.chk[3]) cmp("instr_fetched", instr_fetched, v.exp_instr);
        step_id++;
    endtask

    vec_t tbl [23];

    initial begin
        rst = 1'b0; rdy = 1'b1; icache_enable = 1'b1; pc_to_fetch = 32'h4;
        jump_wrong = 1'b0; mem_data = 32'd0; mem_success = 1'b0;

        // Reset held with a request pending, then cold miss / hit / conflict.
        tbl[0]  = mk(1'b0,1'b1,1'b1,32'h4,  1'b0,32'h0,       1'b0, C_ALL,1'b0,1'b0,32'h0,  32'h0);
        tbl[1]  = mk(1'b0,1'b1,1'b1,32'h4,  1'b0,32'h0,       1'b0, C_ALL,1'b0,1'b0,32'h0,  32'h0);
        tbl[2]  = mk(1'b1,1'b1,1'b1,32'h4,  1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0,  32'h0);
        tbl[3]  = mk(1'b1,1'b1,1'b1,32'h4,  1'b0,32'h0,       1'b0, C_SMA,1'b0,1'b1,32'h4,  32'h0);
        tbl[4]  = mk(1'b1,1'b1,1'b1,32'h4,  1'b0,32'h0,       1'b0, C_SMA,1'b0,1'b1,32'h4,  32'h0);
        tbl[5]  = mk(1'b1,1'b1,1'b1,32'h4,  1'b0,32'h00A00093,1'b1, C_SMA,1'b0,1'b1,32'h4,  32'h0);
        tbl[6]  = mk(1'b1,1'b1,1'b1,32'h4,  1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0,  32'h00A00093);
        tbl[7]  = mk(1'b1,1'b1,1'b1,32'h4,  1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0,  32'h0);
        tbl[8]  = mk(1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0,  32'h00A00093);
        tbl[9]  = mk(1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0,  32'h0);
        tbl[10] = mk(1'b1,1'b1,1'b1,32'h0,  1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0,  32'h0);
        tbl[11] = mk(1'b1,1'b1,1'b1,32'h0,  1'b0,32'h11111111,1'b1, C_SMA,1'b0,1'b1,32'h0,  32'h0);
        tbl[12] = mk(1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0,  32'h11111111);
        tbl[13] = mk(1'b1,1'b1,1'b1,32'h400,1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0,  32'h0);
        tbl[14] = mk(1'b1,1'b1,1'b1,32'h400,1'b0,32'h22222222,1'b1, C_SMA,1'b0,1'b1,32'h400,32'h0);
        tbl[15] = mk(1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0,  32'h22222222);
        tbl[16] = mk(1'b1,1'b1,1'b1,32'h0,  1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0,  32'h0);
        tbl[17] = mk(1'b1,1'b1,1'b1,32'h0,  1'b0,32'h0,       1'b0, C_SMA,1'b0,1'b1,32'h0,  32'h0);
        tbl[18] = mk(1'b1,1'b1,1'b1,32'h0,  1'b0,32'h33333333,1'b1, C_SMA,1'b0,1'b1,32'h0,  32'h0);
        tbl[19] = mk(1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0,  32'h33333333);
        tbl[20] = mk(1'b1,1'b1,1'b1,32'h7,  1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0,  32'h0);
        tbl[21] = mk(1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0,  32'h00A00093);
        tbl[22] = mk(1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0,  32'h0);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i]);
        end

        // Flush during a miss: MISS -> DRAIN -> IDLE, no response, line still refilled.
        step(mk(1'b1,1'b1,1'b1,32'h10,1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        step(mk(1'b1,1'b1,1'b1,32'h10,1'b1,32'h0,       1'b0, C_SMA,1'b0,1'b1,32'h10,32'h0));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SMA,1'b0,1'b1,32'h10,32'h0));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h44444444,1'b1, C_SMA,1'b0,1'b1,32'h10,32'h0));
        step(mk(1'b1,1'b1,1'b1,32'h10,1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0, 32'h44444444));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));

        // Flush coinciding with mem_success: refill, no response, back to IDLE.
        step(mk(1'b1,1'b1,1'b1,32'h14,1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        step(mk(1'b1,1'b1,1'b1,32'h14,1'b1,32'h55555555,1'b1, C_SMA,1'b0,1'b1,32'h14,32'h0));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        step(mk(1'b1,1'b1,1'b1,32'h14,1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0, 32'h55555555));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));

        // Flush in RESP suppresses the strobe in that same cycle.
        step(mk(1'b1,1'b1,1'b1,32'h4, 1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b1,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));

        // Flush with a request in IDLE: request not sampled; the next miss is served normally.
        step(mk(1'b1,1'b1,1'b1,32'h4, 1'b1,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        step(mk(1'b1,1'b1,1'b1,32'h20,1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        step(mk(1'b1,1'b1,1'b1,32'h20,1'b0,32'h66666666,1'b1, C_SMA,1'b0,1'b1,32'h20,32'h0));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0, 32'h66666666));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));

        // rdy stall for 5 cycles mid-MISS: outputs frozen.
        step(mk(1'b1,1'b1,1'b1,32'h24,1'b0,32'h0,       1'b0, C_SM, 1'b0,1'b0,32'h0, 32'h0));
        for (int k = 0; k < 5; k++) begin
            step(mk(1'b1,1'b0,1'b1,32'h24,1'b0,32'h0,   1'b0, C_ALL,1'b0,1'b1,32'h24,32'h66666666));
        end
        step(mk(1'b1,1'b1,1'b1,32'h24,1'b0,32'h77777777,1'b1, C_SMA,1'b0,1'b1,32'h24,32'h0));
        // rdy stall for 5 cycles in RESP: the single pulse is extended, not repeated.
        for (int k = 0; k < 5; k++) begin
            step(mk(1'b1,1'b0,1'b1,32'h24,1'b0,32'h0,   1'b0, C_SMI,1'b1,1'b0,32'h0, 32'h77777777));
        end
        step(mk(1'b1,1'b1,1'b1,32'h24,1'b0,32'h0,       1'b0, C_SMI,1'b1,1'b0,32'h0, 32'h77777777));
        step(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,32'h0,       1'b0, C_SMI,1'b0,1'b0,32'h0, 32'h77777777));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that serves the fetch unit's single-outstanding word requests. Hits return in one cycle. Misses issue a word read to the memory controller and refill the line. A branch-mispredict flush from the ROB cancels the in-flight response without corrupting cache contents. The block sits between IF and the memory-controller arbiter.

## Interface
Parameters:
- INDEX_BITS, 8, log2 of the number of lines (one 32-bit word per line).
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  Clock, rising edge.
- rst  in  1  Reset, synchronous, active-low (rst==0 resets on the clk edge).
- rdy  in  1  Global ready; 0 freezes all state.
- icache_enable  in  1  Fetch request, level, held by IF until success.
- pc_to_fetch  in  ADDR_WIDTH  Request address; bits [1:0] are ignored.
- instr_fetched  out  32  Instruction word; valid while icache_success=1.
- icache_success  out  1  One-cycle response strobe.
- jump_wrong  in  1  ROB flush; cancels the current request.
- mem_enable  out  1  Word read request to the memory controller, level.
- mem_addr  out  ADDR_WIDTH  Word-aligned read address.
- mem_data  in  32  Read data; valid with mem_success.
- mem_success  in  1  One-cycle completion strobe from the memory controller.

## Operation
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[ADDR_WIDTH-1:INDEX_BITS+2]
- Storage is register arrays: valid[2^INDEX_BITS], tag[], data[].
- States: IDLE, MISS, RESP, DRAIN.
- Reset (rst==0): state=IDLE; all valid bits=0; icache_success=0; mem_enable=0; instr_fetched=0; mem_addr=0.
- IDLE, icache_enable=1 and jump_wrong=0:
  - Hit (valid[index] and tag match): instr_fetched<=data[index], icache_success<=1, go RESP.
  - Miss: mem_addr<={pc[ADDR_WIDTH-1:2],2'b00}, mem_enable<=1, latch index/tag, go MISS.
- MISS:
  - Hold mem_enable=1 and mem_addr stable until mem_success.
  - On mem_success: write data, tag and valid=1 for the latched index; instr_fetched<=mem_data; icache_success<=1; mem_enable<=0; go RESP.
- RESP: icache_success=1 for exactly this cycle. icache_enable is ignored. Go IDLE next cycle with icache_success<=0.
- DRAIN: hold mem_enable=1 until mem_success. On mem_success, refill the line as in MISS but keep icache_success=0, drop mem_enable, go IDLE.
- jump_wrong=1 (priority below reset, above everything else):
  - In IDLE: the request is not sampled.
  - In RESP: icache_success is forced to 0 this cycle, go IDLE.
  - In MISS with mem_success=0: go DRAIN.
  - In MISS with mem_success=1: refill the line, no success, go IDLE.
  - In DRAIN: stay in DRAIN.
- Memory is never aborted mid-transfer, and refilled data is always correct for its address, so a flush never invalidates lines.
- rdy=0: no state, array or output register changes. A RESP cycle that starts with rdy=0 is extended until rdy=1. mem_success arriving while rdy=0 is not a legal input.
- Replacement: direct-mapped overwrite on refill. No write or invalidate port.

## Timing
- Hit latency: request sampled at edge N; icache_success=1 during cycle N+1.
- Back-to-back hits: one every 2 cycles, because RESP is always followed by IDLE.
- Miss latency: mem_enable rises in cycle N+1. If mem_success arrives at cycle M, icache_success=1 in cycle M+1.
- Refill write and response are registered on the same edge. A request in the cycle after RESP to the same line hits.
- After a flush, the earliest new request is sampled:
  - from IDLE: the cycle after the flush;
  - from DRAIN: the cycle after DRAIN exits.
- mem_enable never glitches low between request and mem_success.

## Test plan
- Reset: hold rst=0 for 2 cycles with icache_enable=1 -> icache_success=0, mem_enable=0; after release, every access misses.
- Cold miss then hit: request 0x00000004; memory returns 0x00A00093 after 3 cycles -> mem_addr=0x4, icache_success pulses once with 0x00A00093 in cycle M+1. A re-request of 0x4 hits with 1-cycle latency and mem_enable stays 0.
- Conflict (INDEX_BITS=8): fill 0x000, then 0x400 (same index, tag 1) -> second request misses. A later request to 0x000 misses again and refetches.
- Flush during miss: request 0x10, pulse jump_wrong one cycle before mem_success -> no icache_success, mem_enable held until mem_success, state returns to IDLE. A new request to 0x10 then hits.
- Flush in RESP and flush with an IDLE request -> icache_success=0 that cycle, no spurious response, and the next request is served normally.
- rdy=0 for 5 cycles mid-MISS and during RESP -> outputs frozen, exactly one success pulse, and instr_fetched unchanged across the stall.
